frame_collector: RTL
====================

FRAME_COLLECTOR -- requirements
Module: frame_collector

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 640, pixels per line.
REQ-002 SHALL have parameter IMG_HEIGHT, default 480, lines per frame.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, pixel bits.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port pixel_in  input  DATA_WIDTH  pixel from the upstream filter's pixel_out.
REQ-007 SHALL have port pixel_in_valid  input  1  pixel_in qualifier, one pixel per asserted cycle.
REQ-008 SHALL have port src_busy  input  1  upstream filter busy flag.
REQ-009 SHALL have port frame_ack  input  1  consumer has taken the completed frame.
REQ-010 SHALL have port wr_addr  output  ADDR_W=clog2(IMG_WIDTH*IMG_HEIGHT)  linear buffer address y*IMG_WIDTH+x.
REQ-011 SHALL have port wr_data  output  DATA_WIDTH  registered copy of pixel_in.
REQ-012 SHALL have port wr_en  output  1  buffer write strobe.
REQ-013 SHALL have ports x_out  output  clog2(IMG_WIDTH)  and  y_out  output  clog2(IMG_HEIGHT): coordinate of the pixel on wr_data.
REQ-014 SHALL have ports sof, eol, eof  output  1 each: start-of-frame, end-of-line, end-of-frame markers aligned with wr_en.
REQ-015 SHALL have port frame_ready  output  1  a full frame is held, awaiting frame_ack.
REQ-016 SHALL have ports overflow, short_frame  output  1 each: sticky error flags.

Function
REQ-017 SHALL implement FSM states IDLE, COLLECT, HOLD, ERROR.
REQ-018 IDLE: SHALL go to COLLECT on the first pixel_in_valid; that pixel is written at (0,0) with sof=1.
REQ-019 COLLECT: SHALL write each valid pixel with exactly 1-cycle latency (wr_en, wr_data, wr_addr, x_out, y_out, markers all registered).
REQ-020 Coordinates SHALL raster-advance: x wraps IMG_WIDTH-1->0 with y+1; eol=1 when x=IMG_WIDTH-1.
REQ-021 The write at (IMG_WIDTH-1, IMG_HEIGHT-1) SHALL assert eof and eol; the next state SHALL be HOLD with frame_ready=1.
REQ-022 wr_addr SHALL be kept as a running counter, never a multiplier; it reaches IMG_WIDTH*IMG_HEIGHT-1 at eof.
REQ-023 Gaps in pixel_in_valid during COLLECT SHALL be tolerated; counters hold, wr_en=0.
REQ-024 src_busy falling while in COLLECT before eof SHALL set short_frame and enter ERROR.
REQ-025 HOLD: pixel_in_valid SHALL NOT write (wr_en=0); it SHALL set overflow and leave the pixel dropped.
REQ-026 HOLD: frame_ack SHALL clear frame_ready and return to IDLE next cycle.
REQ-027 frame_ack outside HOLD SHALL be ignored.
REQ-028 Simultaneous frame_ack and pixel_in_valid in HOLD: SHALL set overflow, drop the pixel, and go to IDLE; the next frame starts on the next valid.
REQ-029 ERROR: SHALL keep wr_en=0; it SHALL return to IDLE when frame_ack=1 or src_busy rises, and SHALL NOT clear the sticky flags.
REQ-030 overflow and short_frame SHALL clear only on reset.
REQ-031 sof, eol, eof, wr_en SHALL be single-cycle pulses.

Reset
REQ-032 On reset=0 the block SHALL asynchronously force IDLE and zero x/y/address counters.
REQ-033 On reset=0 it SHALL drive wr_en, wr_data, wr_addr, x_out, y_out, sof, eol, eof, frame_ready, overflow, short_frame to 0.
REQ-034 Reset mid-COLLECT SHALL discard the partial frame; after release the next valid pixel is (0,0).

Structure
REQ-035 A shared package pixel_stream_pkg SHALL hold the FSM state typedef and the default IMG_WIDTH/IMG_HEIGHT/DATA_WIDTH constants.
REQ-036 The x/y/linear counter SHALL be one sub-module raster_counter (enable, clear, x, y, addr, eol, eof), reusable by stream sources.

Verification
REQ-037 Reset, then 4x3 frame (params 4,3), continuous valid, data=index: wr_addr 0..11 with wr_data 0..11; sof at addr 0; eol at 3,7,11; eof at 11; frame_ready=1 next cycle.
REQ-038 Same frame with valid toggling every other cycle: identical write sequence, 12 wr_en pulses total.
REQ-039 In HOLD, assert pixel_in_valid 2 cycles: no wr_en, overflow=1; then frame_ack: frame_ready=0, next frame at addr 0.
REQ-040 src_busy drops after 5 pixels: short_frame=1, ERROR, no further writes; src_busy rise: IDLE, next write at addr 0.
REQ-041 Reset asserted asynchronously after 7 pixels: all outputs 0 immediately; after release, the new frame starts at (0,0).
REQ-042 Default 640x480 frame: eof on wr_addr 307199, x_out=639, y_out=479.

Source files
------------

// File: rtl/pixel_stream_pkg.sv
// pixel_stream_pkg: shared FSM state encoding and default image geometry for pixel stream blocks
package pixel_stream_pkg;
   localparam int DEF_IMG_WIDTH  = 640;
   localparam int DEF_IMG_HEIGHT = 480;
   localparam int DEF_DATA_WIDTH = 8;
   typedef logic [1:0] state_t;
   localparam state_t IDLE    = 2'd0;
   localparam state_t COLLECT = 2'd1;
   localparam state_t HOLD    = 2'd2;
   localparam state_t ERROR   = 2'd3;
endpackage

// File: rtl/raster_counter.sv
// raster_counter: raster x/y position plus running linear address of the next pixel
// ports: clk, reset (async active-low), en (advance one pixel), clr (back to origin),
//        x, y, addr (current position), eol/eof (current position is last of line/frame)
module raster_counter #(
   parameter  int W  = 640,
   parameter  int H  = 480,
   localparam int XW = $clog2(W),
   localparam int YW = $clog2(H),
   localparam int AW = $clog2(W * H)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic          clr,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic [AW-1:0] addr,
   output logic          eol,
   output logic          eof
);
   assign eol = x == XW'(W - 1);
   assign eof = eol && y == YW'(H - 1);
   always_ff @(posedge clk or negedge reset)
      if (!reset) {x, y, addr} <= '0;
      else if (clr) {x, y, addr} <= '0;
      else if (en) begin
         x    <= eol ? '0 : x + 1'b1;
         y    <= eof ? '0 : eol ? y + 1'b1 : y;
         addr <= eof ? '0 : addr + 1'b1;
      end
endmodule

// File: rtl/frame_collector.sv
// frame_collector: writes one raster frame from a pixel stream into a linear buffer, then holds it until acked
// ports: clk, reset (async active-low); pixel_in/pixel_in_valid/src_busy from upstream; frame_ack from consumer;
//        wr_addr/wr_data/wr_en/x_out/y_out/sof/eol/eof registered write side; frame_ready; sticky overflow/short_frame
module frame_collector
   import pixel_stream_pkg::*;
#(
   parameter  int IMG_WIDTH  = DEF_IMG_WIDTH,
   parameter  int IMG_HEIGHT = DEF_IMG_HEIGHT,
   parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
   localparam int ADDR_W     = $clog2(IMG_WIDTH * IMG_HEIGHT),
   localparam int X_W        = $clog2(IMG_WIDTH),
   localparam int Y_W        = $clog2(IMG_HEIGHT)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] pixel_in,
   input  logic                  pixel_in_valid,
   input  logic                  src_busy,
   input  logic                  frame_ack,
   output logic [ADDR_W-1:0]     wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wr_en,
   output logic [X_W-1:0]        x_out,
   output logic [Y_W-1:0]        y_out,
   output logic                  sof,
   output logic                  eol,
   output logic                  eof,
   output logic                  frame_ready,
   output logic                  overflow,
   output logic                  short_frame
);
   state_t state, next;
   logic busy_q, fell, rose, accept;
   logic [X_W-1:0] c_x;
   logic [Y_W-1:0] c_y;
   logic [ADDR_W-1:0] c_addr;
   logic c_eol, c_eof;
   assign fell = busy_q && !src_busy;
   assign rose = !busy_q && src_busy;
   assign frame_ready = state == HOLD;
   // a source dropping busy aborts the frame unless this very cycle completes it
   assign accept = pixel_in_valid && (state == IDLE || (state == COLLECT && !(fell && !c_eof)));
   always_comb
      next = state == IDLE    ? (accept ? (c_eof ? HOLD : COLLECT) : IDLE)
           : state == COLLECT ? (accept && c_eof ? HOLD : fell ? ERROR : COLLECT)
           : state == HOLD    ? (frame_ack ? IDLE : HOLD)
           :                    (frame_ack || rose ? IDLE : ERROR);
   raster_counter #(.W(IMG_WIDTH), .H(IMG_HEIGHT)) u_cnt (
      .clk  (clk),
      .reset(reset),
      .en   (accept),
      .clr  (state == HOLD || state == ERROR),
      .x    (c_x),
      .y    (c_y),
      .addr (c_addr),
      .eol  (c_eol),
      .eof  (c_eof)
   );
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state       <= IDLE;
         busy_q      <= 1'b0;
         wr_en       <= 1'b0;
         wr_data     <= '0;
         wr_addr     <= '0;
         x_out       <= '0;
         y_out       <= '0;
         sof         <= 1'b0;
         eol         <= 1'b0;
         eof         <= 1'b0;
         overflow    <= 1'b0;
         short_frame <= 1'b0;
      end else begin
         state       <= next;
         busy_q      <= src_busy;
         wr_en       <= accept;
         sof         <= accept && state == IDLE;
         eol         <= accept && c_eol;
         eof         <= accept && c_eof;
         overflow    <= overflow || (state == HOLD && pixel_in_valid);
         short_frame <= short_frame || (state == COLLECT && next == ERROR);
         if (accept) begin
            wr_data <= pixel_in;
            wr_addr <= c_addr;
            x_out   <= c_x;
            y_out   <= c_y;
         end
      end
endmodule
